// File: rtl/fetch_sequencer.sv
// Instruction-fetch and control sequencer: drives PC controls, runs a handshaked
// memory fetch into the instruction register, and sequences branch/halt/interrupt.
module fetch_sequencer #(
  parameter logic [15:0] IRQ_VECTOR  = 16'h0004,
  parameter logic [7:0]  MEM_TIMEOUT = 8'd255
) (
  input  logic        clk,
  input  logic        r,
  input  logic        run,
  input  logic [15:0] pc_in,
  input  logic        mem_rdy,
  input  logic [15:0] mem_data,
  input  logic        exec_done,
  input  logic        halt_req,
  input  logic        br_take,
  input  logic        iret,
  input  logic [15:0] br_target,
  input  logic        irq,
  output logic        pc_r,
  output logic        pc_we,
  output logic        pc_oe,
  output logic        pc_e,
  output logic [15:0] pc_d,
  output logic        mem_rd,
  output logic [15:0] ir,
  output logic        ir_valid,
  output logic        irq_ack,
  output logic [15:0] epc,
  output logic        halted,
  output logic        fault,
  output logic [2:0]  state
);

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StFetch  = 3'd1,
    StWait   = 3'd2,
    StDecode = 3'd3,
    StExec   = 3'd4,
    StBranch = 3'd5,
    StIrq    = 3'd6,
    StHalt   = 3'd7
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] ir_q, ir_d;
  logic [15:0] epc_q, epc_d;
  logic [15:0] tgt_q, tgt_d;
  logic [7:0]  wcnt_q, wcnt_d;
  logic        ie_q, ie_d;
  logic        fault_q, fault_d;
  logic        br_q, br_d;
  logic        pc_r_q;
  logic [7:0]  wcnt_inc;

  assign wcnt_inc = wcnt_q + 8'd1;

  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    epc_d   = epc_q;
    tgt_d   = tgt_q;
    wcnt_d  = wcnt_q;
    ie_d    = ie_q;
    fault_d = fault_q;
    br_d    = br_q;
    unique case (state_q)
      StIdle: begin
        if (run) state_d = StFetch;
      end
      StFetch: begin
        wcnt_d  = 8'd0;
        state_d = StWait;
      end
      StWait: begin
        if (mem_rdy) begin
          ir_d    = mem_data;
          state_d = StDecode;
        end else begin
          wcnt_d = wcnt_inc;
          if (wcnt_inc == MEM_TIMEOUT) begin
            fault_d = 1'b1;
            state_d = StHalt;
          end
        end
      end
      StDecode: state_d = StExec;
      StExec: begin
        if (exec_done) begin
          tgt_d = br_target;
          br_d  = br_take;
          if (halt_req) begin
            state_d = StHalt;
          end else if (iret) begin
            tgt_d   = epc_q;
            ie_d    = 1'b1;
            state_d = StBranch;
          end else if (irq && ie_q) begin
            state_d = StIrq;
          end else if (br_take) begin
            state_d = StBranch;
          end else if (run) begin
            state_d = StFetch;
          end else begin
            state_d = StIdle;
          end
        end
      end
      StIrq: begin
        // A branch decided alongside the interrupt resumes at its target on iret.
        epc_d   = br_q ? tgt_q : pc_in;
        ie_d    = 1'b0;
        state_d = run ? StFetch : StIdle;
      end
      StBranch: state_d = run ? StFetch : StIdle;
      StHalt:   state_d = StHalt;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!r) begin
      state_q <= StIdle;
      ir_q    <= 16'h0000;
      epc_q   <= 16'h0000;
      tgt_q   <= 16'h0000;
      wcnt_q  <= 8'd0;
      ie_q    <= 1'b1;
      fault_q <= 1'b0;
      br_q    <= 1'b0;
      pc_r_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      epc_q   <= epc_d;
      tgt_q   <= tgt_d;
      wcnt_q  <= wcnt_d;
      ie_q    <= ie_d;
      fault_q <= fault_d;
      br_q    <= br_d;
      pc_r_q  <= 1'b0;
    end
  end

  always_comb begin
    pc_we    = 1'b0;
    pc_oe    = 1'b0;
    pc_e     = 1'b0;
    pc_d     = 16'h0000;
    mem_rd   = 1'b0;
    ir_valid = 1'b0;
    irq_ack  = 1'b0;
    halted   = 1'b0;
    unique case (state_q)
      StFetch, StWait: begin
        pc_oe  = 1'b1;
        mem_rd = 1'b1;
      end
      StDecode: begin
        ir_valid = 1'b1;
        pc_e     = 1'b1;
      end
      StIrq: begin
        pc_we   = 1'b1;
        pc_d    = IRQ_VECTOR;
        irq_ack = 1'b1;
      end
      StBranch: begin
        pc_we = 1'b1;
        pc_d  = tgt_q;
      end
      StHalt: halted = 1'b1;
      StIdle, StExec: ;
    endcase
  end

  assign pc_r  = pc_r_q;
  assign ir    = ir_q;
  assign epc   = epc_q;
  assign fault = fault_q;
  assign state = state_q;

endmodule
